// File: rtl/memory_access_if.sv
// ---------------------------------------------------------------------------
// memory_access_if
// Groups every execute-side handshake signal and the data-memory bus used by
// memory_access into one bundle.
//   master : the memory_access block itself. It takes instructions from
//            execute, returns results to write-back and drives the
//            data-memory request bus.
//   slave  : the surrounding environment, i.e. the execute stage, the
//            write-back stage and the data memory.
// Signals:
//   valid, instruction, address, store_data  execute -> block
//   ready, out_valid, out, error             block -> execute / write-back
//   mem_req, mem_we, mem_addr, mem_wdata     block -> data memory
//   mem_rdata, mem_ack                       data memory -> block
// ---------------------------------------------------------------------------
interface memory_access_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] store_data;
  logic                  ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out;
  logic                  error;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    input  valid, instruction, address, store_data, mem_rdata, mem_ack,
    output ready, out_valid, out, error, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output valid, instruction, address, store_data, mem_rdata, mem_ack,
    input  ready, out_valid, out, error, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access
// Memory stage of the pipeline. It accepts one instruction at a time from
// execute. LW and SW instructions (opcode in the top five instruction bits,
// 5'b00000 = LW, 5'b00001 = SW) are turned into a single data-memory request
// that is held until mem_ack. Every other opcode completes straight away
// without touching memory. Each completed instruction produces a one-cycle
// out_valid pulse. On that pulse, out carries the loaded word for LW or the
// stored word for SW. For non-memory opcodes, out is left unchanged.
//
// Parameters:
//   DATA_WIDTH      width of the instruction, address and data buses
//   TIMEOUT_CYCLES  maximum number of ACCESS cycles to wait for mem_ack
//                   (only used when the timeout option is built in)
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    memory_access_if.master (execute handshake, result, memory bus)
//
// Build option:
//   MEMORY_ACCESS_TIMEOUT_EN  When defined, an access that sees no mem_ack
//                             within TIMEOUT_CYCLES cycles is aborted. The
//                             block then returns out = 0 with error pulsed
//                             alongside out_valid. A mem_ack arriving in the
//                             expiry cycle still completes normally.
//                             When undefined, ACCESS waits indefinitely and
//                             error is tied low.
// ---------------------------------------------------------------------------
module memory_access #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  memory_access_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [4:0] OP_LW = 5'b00000;
  localparam logic [4:0] OP_SW = 5'b00001;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q,    we_d;
  logic [DATA_WIDTH-1:0] out_q,   out_d;

  logic [4:0] opcode;
  logic       is_mem_op;
  logic       expire;

  assign opcode    = bus.instruction[DATA_WIDTH-1 -: 5];
  assign is_mem_op = (opcode == OP_LW) || (opcode == OP_SW);

`ifdef MEMORY_ACCESS_TIMEOUT_EN
  // The counter holds the number of ACCESS cycles already completed without
  // an ack. Expiry therefore fires in the TIMEOUT_CYCLES-th ACCESS cycle.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign expire = (state_q == ACCESS) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == ACCESS) && !bus.mem_ack && !expire) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // err_q is only ever set on the edge entering DONE. It clears again on the
  // way out, so it can only be seen together with out_valid.
  always_comb begin
    err_d = 1'b0;
    if ((state_q == ACCESS) && !bus.mem_ack && expire) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = is_mem_op ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (bus.mem_ack || expire) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.ready     = (state_q == IDLE);
    bus.mem_req   = (state_q == ACCESS);
    bus.out_valid = (state_q == DONE);
`ifdef MEMORY_ACCESS_TIMEOUT_EN
    bus.error     = (state_q == DONE) && err_q;
`else
    bus.error     = 1'b0;
`endif
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.out       = out_q;

  // Request fields are captured only when a memory op is accepted. They stay
  // frozen for the whole of ACCESS and beyond.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid && is_mem_op) begin
          addr_d  = bus.address;
          wdata_d = bus.store_data;
          we_d    = (opcode == OP_SW);
        end
      end
      ACCESS: begin
        // An ack wins over a simultaneous timeout expiry.
        if (bus.mem_ack) begin
          out_d = we_q ? wdata_q : bus.mem_rdata;
        end else if (expire) begin
          out_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// ---------------------------------------------------------------------------
// tb_memory_access
// Directed, self-checking bench for memory_access. Each issued instruction
// pushes its expected result (out, error) into a scoreboard queue. The entry
// is popped and compared when out_valid appears. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_memory_access;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  memory_access_if #(.DATA_WIDTH(DW)) bus ();

  memory_access #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [DW-1:0] out;
    logic          err;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned req_count = 0;
  logic        req_prev  = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and count rising edges of mem_req.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.mem_req === 1'b1 && req_prev !== 1'b1) req_count++;
    req_prev = bus.mem_req;
  endtask

  task automatic issue(input logic [4:0] op, input logic [DW-1:0] addr, input logic [DW-1:0] sdata);
    for (int i = 0; i < 20 && bus.ready !== 1'b1; i++) tick();
    chk("ready_before_issue", {31'd0, bus.ready}, 1);
    bus.valid       = 1'b1;
    bus.instruction = {op, 27'h0};
    bus.address     = addr;
    bus.store_data  = sdata;
    tick();
    bus.valid       = 1'b0;
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 1);
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_out"}, bus.out, e.out);
      chk({tag, "_error"}, {31'd0, bus.error}, {31'd0, e.err});
    end
  endtask

  // One LW/SW transaction. The memory acks in ACCESS cycle w+1.
  task automatic mem_op(input string tag, input logic [4:0] op, input logic [DW-1:0] addr,
                        input logic [DW-1:0] sdata, input int unsigned w,
                        input logic [DW-1:0] rdata, input logic [DW-1:0] exp_out);
    sb.push_back('{out: exp_out, err: 1'b0});
    issue(op, addr, sdata);
    chk({tag, "_req"},   {31'd0, bus.mem_req}, 1);
    chk({tag, "_ready"}, {31'd0, bus.ready}, 0);
    chk({tag, "_we"},    {31'd0, bus.mem_we}, {31'd0, op == 5'b00001});
    chk({tag, "_addr"},  bus.mem_addr, addr);
    chk({tag, "_wdata"}, bus.mem_wdata, sdata);
    for (int i = 0; i < int'(w); i++) begin
      tick();
      chk({tag, "_req_hold"},  {31'd0, bus.mem_req}, 1);
      chk({tag, "_addr_hold"}, bus.mem_addr, addr);
      chk({tag, "_no_valid"},  {31'd0, bus.out_valid}, 0);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    check_done(tag);
    chk({tag, "_req_low_done"}, {31'd0, bus.mem_req}, 0);
    tick();
    chk({tag, "_pulse_end"}, {31'd0, bus.out_valid}, 0);
    chk({tag, "_ready_back"}, {31'd0, bus.ready}, 1);
    chk({tag, "_out_hold"}, bus.out, exp_out);
  endtask

  initial begin
    int unsigned r0;
    logic [DW-1:0] prev;

    rst             = 1'b1;
    bus.valid       = 1'b0;
    bus.instruction = '0;
    bus.address     = '0;
    bus.store_data  = '0;
    bus.mem_rdata   = '0;
    bus.mem_ack     = 1'b0;
    tick();
    tick();
    chk("rst_ready",     {31'd0, bus.ready}, 1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_out",       bus.out, 0);
    chk("rst_error",     {31'd0, bus.error}, 0);
    chk("rst_req",       {31'd0, bus.mem_req}, 0);
    chk("rst_we",        {31'd0, bus.mem_we}, 0);
    chk("rst_addr",      bus.mem_addr, 0);
    chk("rst_wdata",     bus.mem_wdata, 0);
    rst = 1'b0;
    tick();

    // LW with ack in the third ACCESS cycle
    mem_op("lw_wait3", 5'b00000, 32'h0000_0040, 32'h0, 2, 32'h8F38_FAAA, 32'h8F38_FAAA);

    // SW with zero-wait ack: out_valid two cycles after acceptance
    mem_op("sw_zero", 5'b00001, 32'h0000_0080, 32'hF238_FAAA, 0, 32'h1111_2222, 32'hF238_FAAA);

    // Non-memory opcodes complete immediately with out unchanged
    prev = 32'hF238_FAAA;
    r0   = req_count;
    for (int op = 2; op <= 18; op++) begin
      sb.push_back('{out: prev, err: 1'b0});
      issue(5'(op), 32'h0000_1000 + 32'(op), 32'hABCD_0000 + 32'(op));
      chk("nonmem_req", {31'd0, bus.mem_req}, 0);
      check_done("nonmem");
      tick();
      chk("nonmem_idle", {31'd0, bus.ready}, 1);
    end
    chk("nonmem_no_requests", req_count - r0, 0);

    // Reset in the second ACCESS cycle, with a simultaneous ack and new valid
    issue(5'b00000, 32'h0000_0080, 32'h0000_1234);
    tick();
    chk("rstacc_req_before", {31'd0, bus.mem_req}, 1);
    rst             = 1'b1;
    bus.mem_ack     = 1'b1;
    bus.mem_rdata   = 32'h5555_5555;
    bus.valid       = 1'b1;
    bus.instruction = {5'b00001, 27'h0};
    tick();
    rst         = 1'b0;
    bus.mem_ack = 1'b0;
    bus.valid   = 1'b0;
    chk("rstacc_req",       {31'd0, bus.mem_req}, 0);
    chk("rstacc_ready",     {31'd0, bus.ready}, 1);
    chk("rstacc_out",       bus.out, 0);
    chk("rstacc_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rstacc_error",     {31'd0, bus.error}, 0);
    chk("rstacc_addr",      bus.mem_addr, 0);
    chk("rstacc_wdata",     bus.mem_wdata, 0);
    chk("rstacc_we",        {31'd0, bus.mem_we}, 0);
    tick();
    chk("rstacc_no_pulse",  {31'd0, bus.out_valid}, 0);
    chk("rstacc_sb_empty",  sb.size(), 0);

    // mem_ack while idle is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    tick();
    bus.mem_ack   = 1'b0;
    chk("idle_ack_ready",     {31'd0, bus.ready}, 1);
    chk("idle_ack_out_valid", {31'd0, bus.out_valid}, 0);
    chk("idle_ack_out",       bus.out, 0);

    // Second valid LW while busy is ignored: exactly one request
    r0 = req_count;
    sb.push_back('{out: 32'hCAFE_0001, err: 1'b0});
    issue(5'b00000, 32'h0000_0044, 32'h0);
    bus.valid       = 1'b1;
    bus.instruction = {5'b00000, 27'h0};
    bus.address     = 32'h0000_0100;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("busy_addr_hold", bus.mem_addr, 32'h0000_0044);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    tick();
    bus.mem_ack   = 1'b0;
    check_done("busy");
    chk("busy_addr_done", bus.mem_addr, 32'h0000_0044);
    bus.valid = 1'b0;
    tick();
    chk("busy_ready", {31'd0, bus.ready}, 1);
    tick();
    chk("busy_req_idle", {31'd0, bus.mem_req}, 0);
    chk("busy_one_request", req_count - r0, 1);

`ifdef MEMORY_ACCESS_TIMEOUT_EN
    // No ack: request held for 4 cycles, then abort with error
    sb.push_back('{out: 32'h0, err: 1'b1});
    issue(5'b00000, 32'h0000_0200, 32'h0);
    chk("to_req_c1", {31'd0, bus.mem_req}, 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("to_req_hold", {31'd0, bus.mem_req}, 1);
    end
    tick();
    check_done("timeout");
    chk("to_req_dropped", {31'd0, bus.mem_req}, 0);
    tick();
    chk("to_error_clear", {31'd0, bus.error}, 0);
    chk("to_pulse_end",   {31'd0, bus.out_valid}, 0);

    // Ack in the expiry cycle wins
    mem_op("ack_at_expiry", 5'b00000, 32'h0000_0204, 32'h0, 3, 32'h0BAD_F00D, 32'h0BAD_F00D);
`else
    // Without the timeout option a long wait still completes normally
    mem_op("long_wait", 5'b00000, 32'h0000_0204, 32'h0, 10, 32'h0BAD_F00D, 32'h0BAD_F00D);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of the address, data and instruction buses.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16: maximum wait for mem_ack (used only under REQ-029).
REQ-003 The block SHALL have port clock  input  1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 The block SHALL have port valid  input  1: instruction/address/store_data valid from execute.
REQ-006 The block SHALL have port instruction  input  DATA_WIDTH: opcode in [31:27]; 5'b00000 = LW, 5'b00001 = SW, others = non-memory.
REQ-007 The block SHALL have port address  input  DATA_WIDTH: ALU result used as the memory address.
REQ-008 The block SHALL have port store_data  input  DATA_WIDTH: word to write on SW.
REQ-009 The block SHALL have port ready  output  1: high when a new instruction can be accepted.
REQ-010 The block SHALL have port out_valid  output  1: one-cycle pulse marking a completed instruction.
REQ-011 The block SHALL have port out  output  DATA_WIDTH: memory result, feeds the write-back memory_in.
REQ-012 The block SHALL have port error  output  1: access aborted by timeout, pulsed with out_valid.
REQ-013 The block SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, DATA_WIDTH) and mem_wdata (output, DATA_WIDTH): data-memory request bus.
REQ-014 The block SHALL have ports mem_rdata (input, DATA_WIDTH) and mem_ack (input, 1): data-memory response.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, ACCESS and DONE; ready SHALL equal (state == IDLE).
REQ-016 In IDLE, valid with an LW/SW opcode SHALL register address, store_data and the opcode and enter ACCESS on the next edge.
REQ-017 In IDLE, valid with a non-memory opcode SHALL enter DONE without a memory request; out SHALL keep its previous value.
REQ-018 In ACCESS, mem_req SHALL be high; mem_addr, mem_wdata and mem_we (1 for SW, 0 for LW) SHALL stay constant until mem_ack is sampled.
REQ-019 mem_ack sampled high in ACCESS SHALL end the request: the next state is DONE and mem_req is low in DONE.
REQ-020 On LW completion, out SHALL load mem_rdata sampled in the mem_ack cycle; on SW completion, out SHALL load the registered store_data.
REQ-021 In DONE, out_valid SHALL be high for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-022 Latency: acceptance edge N, then mem_req high from N+1; ack sampled at edge M gives out_valid during cycle M+1; zero-wait ack gives out_valid in cycle N+2.
REQ-023 mem_ack while not in ACCESS SHALL be ignored.
REQ-024 valid while ready is low SHALL be ignored; upstream holds the instruction until ready.
REQ-025 Outside DONE, out_valid and error SHALL be 0; out SHALL hold its last value.

Reset
REQ-026 reset high at a rising edge SHALL force IDLE and clear out, out_valid, error, mem_req, mem_we, mem_addr, mem_wdata and the timeout counter to 0.
REQ-027 Reset during ACCESS SHALL drop mem_req on that edge, without completion and without an out_valid pulse.
REQ-028 Reset SHALL take priority over valid and mem_ack in the same cycle.

Configuration
REQ-029 With macro MEMORY_ACCESS_TIMEOUT_EN defined, a counter SHALL count cycles in ACCESS; if TIMEOUT_CYCLES cycles elapse without mem_ack, the block SHALL drop mem_req, enter DONE, set out to 0 and pulse error with out_valid.
REQ-030 Under REQ-029, mem_ack in the same cycle the count expires SHALL win: normal completion, error = 0.
REQ-031 Without MEMORY_ACCESS_TIMEOUT_EN, ACCESS SHALL wait for mem_ack indefinitely, error SHALL be tied to 0 and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-032 The bench SHALL cover this LW case: LW, address=0x0000_0040, mem_ack after 3 cycles with mem_rdata=0x8F38_FAAA -> mem_we=0, mem_addr=0x40, out=0x8F38_FAAA, one out_valid pulse.
REQ-033 The bench SHALL cover this SW case: SW, store_data=0xF238_FAAA, zero-wait ack -> mem_we=1, mem_wdata=0xF238_FAAA, out_valid in cycle N+2, out=0xF238_FAAA.
REQ-034 The bench SHALL cover opcodes 2..18 with valid -> mem_req never asserted, out_valid the cycle after acceptance, out unchanged.
REQ-035 The bench SHALL cover: LW, then reset asserted on the 2nd ACCESS cycle -> mem_req=0, all outputs 0 and ready=1 after that edge, no out_valid.
REQ-036 The bench SHALL cover, with MEMORY_ACCESS_TIMEOUT_EN defined and TIMEOUT_CYCLES=4: LW with mem_ack never asserted -> mem_req drops after 4 cycles, out=0, error=1 with out_valid.
REQ-037 The bench SHALL cover: a second valid LW while ready=0 -> ignored, exactly one memory request issued.
